sort_frame_controller: RTL and testbench
========================================

Name: sort_frame_controller

Overview:
- Sequences one recursive bitonic sorter instance (the registered compare/merge tree) for a streaming magnitude-ranking path.
- Packs SLICES serial samples into a frame and tags each with its arrival index. Launches the sorter, waits for its sticky done, then captures the result and clears the sorter with a local reset pulse.
- Emits the OUT_COUNT largest entries serially, with their indices, under valid/ready backpressure. One frame is in flight at a time.

Parameters:
- SLICES, 8, sorter width; power of two, >= 2.
- OUT_COUNT, 2, entries emitted per frame; 1..SLICES.
- TIMEOUT, 1023, max cycles waited for sorter done before the frame is abandoned.
- Data/index widths are the global SLICE_WIDTH and INDEX_WIDTH from core_params.svh. INDEX_WIDTH >= clog2(SLICES).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts a sample.
- in_data  in  SLICE_WIDTH  sample magnitude.
- sort_ready  out  1  one-cycle launch to sorter.
- sort_reset  out  1  sorter reset (reset OR clear pulse).
- sort_data  out  SLICES*SLICE_WIDTH  packed frame to sorter.
- sort_index  out  SLICES*INDEX_WIDTH  packed arrival indices.
- sort_done  in  1  sorter done; sticky until sort_reset.
- sort_data_out  in  SLICES*SLICE_WIDTH  sorted data, ascending toward slot SLICES-1.
- sort_index_out  in  SLICES*INDEX_WIDTH  sorted indices.
- out_valid  out  1  result entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  SLICE_WIDTH  result magnitude.
- out_index  out  INDEX_WIDTH  arrival index of result.
- out_last  out  1  final entry of frame.
- timeout_err  out  1  sticky; set when a frame is abandoned.
- frames_done  out  16  count of fully drained frames; wraps 0xFFFF to 0.

Behaviour:
- States: FILL, LAUNCH, WAIT, CLEAR, DRAIN. Reset state is FILL.
- Reset values:
  - fill_cnt=0, rd_ptr=0, wait_cnt=0.
  - sort_ready=0, out_valid=0, out_last=0, timeout_err=0, frames_done=0.
  - frame and result buffers cleared to 0.
  - sort_reset=1 while reset is high.
- FILL:
  - in_ready=1.
  - On in_valid&&in_ready: slot[fill_cnt] <= in_data, idx[fill_cnt] <= fill_cnt, fill_cnt++.
  - When the sample at fill_cnt==SLICES-1 is accepted: fill_cnt <= 0, next state LAUNCH.
  - in_ready=0 in every other state; in_valid is ignored there.
- LAUNCH:
  - sort_ready=1 for exactly this cycle; sort_data/sort_index are stable from this cycle until CLEAR.
  - wait_cnt <= 0. Next state WAIT.
- WAIT:
  - wait_cnt++ each cycle.
  - If sort_done=1: result buffers <= sort_data_out/sort_index_out, next state CLEAR. sort_done has priority over timeout in the same cycle.
  - Else if wait_cnt==TIMEOUT: timeout_err <= 1, results are not captured, frame is dropped, next state CLEAR with a drop flag set.
- CLEAR:
  - sort_reset=1 for exactly one cycle.
  - Next state is DRAIN, or FILL if the frame was dropped.
- DRAIN:
  - rd_ptr starts at 0. Output slot SLICES-1-rd_ptr.
  - out_valid=1 registered, asserted the cycle after entering DRAIN.
  - out_data/out_index hold stable while out_valid && !out_ready.
  - out_last=1 when rd_ptr==OUT_COUNT-1.
  - On handshake, rd_ptr++. On the handshake with out_last: out_valid <= 0, frames_done++, next state FILL.
- Minimum frame-to-frame gap: LAUNCH(1) + sorter latency + CLEAR(1) + 1 + OUT_COUNT cycles.
- Reset mid-operation: any state returns to FILL next cycle.
  - Partial frame and results are discarded.
  - sort_reset is high for the reset cycle.
  - No out_valid until a new full frame drains.
- Equal magnitudes: emitted order follows sorter output; the controller does not reorder.
- sort_done seen outside WAIT is ignored.

Test Plan:
- SLICES=4, OUT_COUNT=2; feed 5,12,3,9 back-to-back -> (12,idx1) then (9,idx3) with out_last on the second; frames_done=1; sort_ready high exactly 1 cycle; sort_reset high exactly 1 cycle before the first out_valid.
- Same frame, out_ready low 5 cycles then high -> out_data holds 12/idx1 for all stall cycles; no duplicate or lost entry; in_ready=0 until after the last handshake.
- Gapped input (in_valid toggling 1,0,1,0...) of 7,7,1,2 -> exactly 4 accepts; launch only after the 4th; outputs have magnitude 7 with indices {0,1} and the last flag correct.
- Sorter stub never asserts done, TIMEOUT=15 -> timeout_err=1 after 16 WAIT cycles; one sort_reset pulse; no out_valid; FILL resumes; the next good frame still drains correctly.
- Reset asserted after 2 of 4 samples, then 4 new samples 1,2,3,4 -> output (4,idx3),(3,idx2); the pre-reset samples never appear.
- 65536 frames (or frames_done forced to 0xFFFF) -> wraps to 0 on the next drained frame; timeout_err stays unchanged.

Source files
------------

// File: rtl/sort_frame_controller_if.sv
// Bundle of the sample stream, sorter, and result stream signals around one sort_frame_controller.
// The controller uses the master modport; the sorter and the stream endpoints use the slave modport.
interface sort_frame_controller_if #(
  parameter int SLICES      = 8,
  parameter int SLICE_WIDTH = 16,
  parameter int INDEX_WIDTH = 8
);
  logic                           in_valid;
  logic                           in_ready;
  logic [SLICE_WIDTH-1:0]         in_data;

  logic                           sort_ready;
  logic                           sort_reset;
  logic [SLICES*SLICE_WIDTH-1:0]  sort_data;
  logic [SLICES*INDEX_WIDTH-1:0]  sort_index;
  logic                           sort_done;
  logic [SLICES*SLICE_WIDTH-1:0]  sort_data_out;
  logic [SLICES*INDEX_WIDTH-1:0]  sort_index_out;

  logic                           out_valid;
  logic                           out_ready;
  logic [SLICE_WIDTH-1:0]         out_data;
  logic [INDEX_WIDTH-1:0]         out_index;
  logic                           out_last;

  logic                           timeout_err;
  logic [15:0]                    frames_done;

  modport master (
    input  in_valid, in_data, sort_done, sort_data_out, sort_index_out, out_ready,
    output in_ready, sort_ready, sort_reset, sort_data, sort_index,
           out_valid, out_data, out_index, out_last, timeout_err, frames_done
  );

  modport slave (
    output in_valid, in_data, sort_done, sort_data_out, sort_index_out, out_ready,
    input  in_ready, sort_ready, sort_reset, sort_data, sort_index,
           out_valid, out_data, out_index, out_last, timeout_err, frames_done
  );
endinterface

// File: rtl/sort_frame_controller.sv
// Frames serial samples for one bitonic sorter, launches it, waits for done (with timeout),
// clears it, and streams the OUT_COUNT largest entries with their arrival indices.
module sort_frame_controller #(
  parameter int SLICES      = 8,
  parameter int OUT_COUNT   = 2,
  parameter int TIMEOUT     = 1023,
  parameter int SLICE_WIDTH = 16,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  sort_frame_controller_if.master bus
);
  localparam int FILL_W = $clog2(SLICES);
  localparam int RD_W   = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int DW     = SLICES * SLICE_WIDTH;
  localparam int IW     = SLICES * INDEX_WIDTH;

  typedef enum logic [2:0] {FILL, LAUNCH, WAIT, CLEAR, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [RD_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              drop_q, drop_d;
  logic              out_valid_q, out_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic [15:0]       frames_done_q, frames_done_d;
  logic [DW-1:0]     frame_q, frame_d, res_data_q, res_data_d;
  logic [IW-1:0]     idx_q, idx_d, res_idx_q, res_idx_d;

  logic              rd_last;
  logic [FILL_W-1:0] rd_slot;

  assign rd_last = (rd_ptr_q == RD_W'(OUT_COUNT - 1));
  // Largest entries sit at the top slots, so the read walks down from SLICES-1.
  assign rd_slot = FILL_W'(SLICES - 1) - FILL_W'(rd_ptr_q);

  // NOTE: every variable gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wait_cnt_d    = wait_cnt_q;
    drop_d        = drop_q;
    out_valid_d   = out_valid_q;
    timeout_err_d = timeout_err_q;
    frames_done_d = frames_done_q;
    frame_d       = frame_q;
    idx_d         = idx_q;
    res_data_d    = res_data_q;
    res_idx_d     = res_idx_q;

    unique case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          frame_d[int'(fill_cnt_q)*SLICE_WIDTH +: SLICE_WIDTH] = bus.in_data;
          idx_d[int'(fill_cnt_q)*INDEX_WIDTH +: INDEX_WIDTH]   = INDEX_WIDTH'(fill_cnt_q);
          if (fill_cnt_q == FILL_W'(SLICES - 1)) begin
            fill_cnt_d = '0;
            state_d    = LAUNCH;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      LAUNCH: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (bus.sort_done) begin
          res_data_d = bus.sort_data_out;
          res_idx_d  = bus.sort_index_out;
          drop_d     = 1'b0;
          state_d    = CLEAR;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
          timeout_err_d = 1'b1;
          drop_d        = 1'b1;
          state_d       = CLEAR;
        end
      end
      CLEAR: begin
        rd_ptr_d = '0;
        drop_d   = 1'b0;
        state_d  = drop_q ? FILL : DRAIN;
      end
      DRAIN: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          if (rd_last) begin
            out_valid_d   = 1'b0;
            rd_ptr_d      = '0;
            frames_done_d = frames_done_q + 16'd1;
            state_d       = FILL;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      fill_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wait_cnt_q    <= '0;
      drop_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      frames_done_q <= '0;
      // NOTE: the buffers are a handful of flops, not RAM, so clearing them on reset is cheap
      // and guarantees no stale sample can ever leak into a later frame.
      frame_q       <= '0;
      idx_q         <= '0;
      res_data_q    <= '0;
      res_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wait_cnt_q    <= wait_cnt_d;
      drop_q        <= drop_d;
      out_valid_q   <= out_valid_d;
      timeout_err_q <= timeout_err_d;
      frames_done_q <= frames_done_d;
      frame_q       <= frame_d;
      idx_q         <= idx_d;
      res_data_q    <= res_data_d;
      res_idx_q     <= res_idx_d;
    end
  end

  assign bus.in_ready    = (state_q == FILL);
  assign bus.sort_ready  = (state_q == LAUNCH);
  assign bus.sort_reset  = reset || (state_q == CLEAR);
  assign bus.sort_data   = frame_q;
  assign bus.sort_index  = idx_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_valid_q && rd_last;
  assign bus.out_data    = res_data_q[int'(rd_slot)*SLICE_WIDTH +: SLICE_WIDTH];
  assign bus.out_index   = res_idx_q[int'(rd_slot)*INDEX_WIDTH +: INDEX_WIDTH];
  assign bus.timeout_err = timeout_err_q;
  assign bus.frames_done = frames_done_q;
endmodule

// File: tb/tb_sort_frame_controller.sv
// Directed bench for sort_frame_controller with a behavioural sorter stub (fixed latency, stable
// ascending sort, optional "never done" mode); expected outputs are hand-computed constants.
module tb_sort_frame_controller;
  localparam int N  = 4;
  localparam int SW = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sort_frame_controller_if #(.SLICES(N), .SLICE_WIDTH(SW), .INDEX_WIDTH(IW)) bus ();

  sort_frame_controller #(
    .SLICES(N), .OUT_COUNT(2), .TIMEOUT(15), .SLICE_WIDTH(SW), .INDEX_WIDTH(IW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Sorter stub: done three cycles after launch, sticky until sort_reset.
  logic        stub_dead;
  logic [47:0] stub_res_q;
  logic        stub_done_q, stub_busy_q;
  int          stub_cnt_q;

  function automatic logic [47:0] sort4(input logic [31:0] d, input logic [15:0] ix);
    logic [7:0] v[4];
    logic [3:0] k[4];
    logic [7:0] tv;
    logic [3:0] tk;
    logic [47:0] r;
    for (int i = 0; i < 4; i++) begin
      v[i] = d[i*8 +: 8];
      k[i] = ix[i*4 +: 4];
    end
    for (int i = 1; i < 4; i++)
      for (int j = i; j > 0; j--)
        if (v[j-1] > v[j]) begin
          tv = v[j]; v[j] = v[j-1]; v[j-1] = tv;
          tk = k[j]; k[j] = k[j-1]; k[j-1] = tk;
        end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[16 + i*8 +: 8] = v[i];
      r[i*4 +: 4]      = k[i];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.sort_reset) begin
      stub_done_q <= 1'b0;
      stub_busy_q <= 1'b0;
      stub_cnt_q  <= 0;
    end else if (bus.sort_ready) begin
      stub_res_q  <= sort4(bus.sort_data, bus.sort_index);
      stub_busy_q <= !stub_dead;
      stub_cnt_q  <= 0;
    end else if (stub_busy_q) begin
      if (stub_cnt_q == 2) begin
        stub_done_q <= 1'b1;
        stub_busy_q <= 1'b0;
      end else begin
        stub_cnt_q <= stub_cnt_q + 1;
      end
    end
  end

  assign bus.sort_done      = stub_done_q;
  assign bus.sort_data_out  = stub_res_q[47:16];
  assign bus.sort_index_out = stub_res_q[15:0];

  // Event monitor: sampled mid-cycle, counters only ever written here.
  int cyc = 0;
  int n_launch = 0, n_clear = 0, n_ovalid = 0, n_overlap = 0, n_acc = 0;
  int clear_cyc = 0, ov_rise_cyc = 0, launch_cyc = 0, terr_cyc = 0;
  logic ov_prev = 1'b0, terr_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sort_ready) begin n_launch++; launch_cyc = cyc; end
    if (bus.sort_reset && !reset) begin n_clear++; clear_cyc = cyc; end
    if (bus.out_valid) n_ovalid++;
    if (bus.out_valid && !ov_prev) ov_rise_cyc = cyc;
    if (bus.out_valid && bus.in_ready) n_overlap++;
    if (bus.in_valid && bus.in_ready) n_acc++;
    if (bus.timeout_err && !terr_prev) terr_cyc = cyc;
    ov_prev   = bus.out_valid;
    terr_prev = bus.timeout_err;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 100; t++) begin
      if (bus.in_ready) begin
        step();
        bus.in_valid = 1'b0;
        return;
      end
      step();
    end
    check("send_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, b, c, d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic recv(input string tag, input logic [7:0] ed, input logic [3:0] ei,
                      input logic el, input int stall);
    int t;
    t = 0;
    bus.out_ready = 1'b0;
    while (!bus.out_valid && t < 200) begin step(); t++; end
    if (!bus.out_valid) begin
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      return;
    end
    for (int s = 0; s < stall; s++) begin
      check({tag, "_stall_data"}, {bus.out_valid, 19'd0, bus.out_index, bus.out_data},
            {1'b1, 19'd0, ei, ed});
      step();
    end
    check({tag, "_data"},  32'(bus.out_data),  32'(ed));
    check({tag, "_index"}, 32'(bus.out_index), 32'(ei));
    check({tag, "_last"},  32'(bus.out_last),  32'(el));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  int s_launch, s_clear, s_ovalid, s_overlap, s_acc;

  task automatic snap();
    s_launch = n_launch; s_clear = n_clear; s_ovalid = n_ovalid;
    s_overlap = n_overlap; s_acc = n_acc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    stub_dead = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_sort_reset", 32'(bus.sort_reset), 32'd1);
    check("rst_sort_ready", 32'(bus.sort_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    check("rst_frames_done", 32'(bus.frames_done), 32'd0);
    reset = 1'b0;
    step();
    check("post_rst_sort_reset", 32'(bus.sort_reset), 32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic frame: 5,12,3,9 -> (12,1) then (9,3, last)
    snap();
    send_frame(8'd5, 8'd12, 8'd3, 8'd9);
    recv("f1_e0", 8'd12, 4'd1, 1'b0, 0);
    recv("f1_e1", 8'd9, 4'd3, 1'b1, 0);
    step(); step();
    check("f1_frames_done", 32'(bus.frames_done), 32'd1);
    check("f1_launch_cycles", 32'(n_launch - s_launch), 32'd1);
    check("f1_clear_cycles", 32'(n_clear - s_clear), 32'd1);
    check("f1_clear_before_valid", 32'(clear_cyc < ov_rise_cyc), 32'd1);
    check("f1_valid_cycles", 32'(n_ovalid - s_ovalid), 32'd2);
    check("f1_out_valid_idle", 32'(bus.out_valid), 32'd0);

    // Same frame with a 5-cycle downstream stall on the first entry
    snap();
    send_frame(8'd5, 8'd12, 8'd3, 8'd9);
    recv("f2_e0", 8'd12, 4'd1, 1'b0, 5);
    recv("f2_e1", 8'd9, 4'd3, 1'b1, 0);
    step(); step();
    check("f2_frames_done", 32'(bus.frames_done), 32'd2);
    check("f2_valid_cycles", 32'(n_ovalid - s_ovalid), 32'd7);
    check("f2_in_ready_overlap", 32'(n_overlap - s_overlap), 32'd0);
    check("f2_in_ready_after", 32'(bus.in_ready), 32'd1);

    // Gapped input 7,7,1,2 -> both 7s (indices 1 then 0 from the stable stub)
    snap();
    send(8'd7); step();
    send(8'd7); step();
    send(8'd1); step();
    check("f3_no_early_launch", 32'(n_launch - s_launch), 32'd0);
    check("f3_in_ready_mid", 32'(bus.in_ready), 32'd1);
    send(8'd2); step();
    recv("f3_e0", 8'd7, 4'd1, 1'b0, 0);
    recv("f3_e1", 8'd7, 4'd0, 1'b1, 0);
    step(); step();
    check("f3_accepts", 32'(n_acc - s_acc), 32'd4);
    check("f3_launches", 32'(n_launch - s_launch), 32'd1);
    check("f3_frames_done", 32'(bus.frames_done), 32'd3);

    // Sorter never finishes -> timeout after 16 WAIT cycles, frame dropped
    stub_dead = 1'b1;
    snap();
    send_frame(8'd1, 8'd1, 8'd1, 8'd1);
    for (int t = 0; t < 100 && !bus.timeout_err; t++) step();
    check("to_err_set", 32'(bus.timeout_err), 32'd1);
    repeat (3) step();
    check("to_latency", 32'(terr_cyc - launch_cyc), 32'd17);
    check("to_clear_pulses", 32'(n_clear - s_clear), 32'd1);
    check("to_no_out_valid", 32'(n_ovalid - s_ovalid), 32'd0);
    check("to_fill_resumed", 32'(bus.in_ready), 32'd1);
    check("to_frames_done", 32'(bus.frames_done), 32'd3);
    stub_dead = 1'b0;
    send_frame(8'd5, 8'd12, 8'd3, 8'd9);
    recv("to_good_e0", 8'd12, 4'd1, 1'b0, 0);
    recv("to_good_e1", 8'd9, 4'd3, 1'b1, 0);
    step();
    check("to_good_frames_done", 32'(bus.frames_done), 32'd4);
    check("to_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Reset mid-fill, then a fresh frame 1,2,3,4
    send(8'd200); send(8'd201);
    reset = 1'b1;
    step();
    check("mid_rst_sort_reset", 32'(bus.sort_reset), 32'd1);
    reset = 1'b0;
    step();
    check("mid_rst_frames_done", 32'(bus.frames_done), 32'd0);
    check("mid_rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    send_frame(8'd1, 8'd2, 8'd3, 8'd4);
    recv("mr_e0", 8'd4, 4'd3, 1'b0, 0);
    recv("mr_e1", 8'd3, 4'd2, 1'b1, 0);
    step();
    check("mr_frames_done", 32'(bus.frames_done), 32'd1);

    // frames_done wraps from 0xFFFF to 0
    force dut.frames_done_q = 16'hFFFF;
    step();
    release dut.frames_done_q;
    step();
    check("wrap_preload", 32'(bus.frames_done), 32'h0000_FFFF);
    send_frame(8'd5, 8'd12, 8'd3, 8'd9);
    recv("wrap_e0", 8'd12, 4'd1, 1'b0, 0);
    recv("wrap_e1", 8'd9, 4'd3, 1'b1, 0);
    step();
    check("wrap_frames_done", 32'(bus.frames_done), 32'd0);
    check("wrap_timeout_err", 32'(bus.timeout_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
